// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states, opcodes and
// datapath select values used by the control FSM, ALU decoder and immediate extender.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational, no latency, no flow control.
// Shared between the control FSM and the immediate extender.
module imm_src_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);

   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_STORE:  imm_src = IMM_S;
         OP_BRANCH: imm_src = IMM_B;
         OP_JAL:    imm_src = IMM_J;
         default:   imm_src = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: 2-5 cycles per instruction, all outputs combinational.
// FETCH, MEMREAD and MEMWRITE stall on mem_ready with outputs held steady.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       alu_f7b5,
   output logic [1:0] imm_src,
   output logic       illegal_instr,
   output logic [3:0] state_dbg
);

   state_t state_q;
   state_t state_d;

   // Only funct3[0] distinguishes beq/bne; the rest is intentionally ignored.
   logic unused_funct3;
   assign unused_funct3 = ^funct3[2:1];

   imm_src_decoder u_imm_src_decoder (
      .op      (op),
      .imm_src (imm_src)
   );

   assign alu_f7b5  = funct7b5 & op[5];
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALU_OP_ADD;
      illegal_instr = 1'b0;

      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            state_d    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default: begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = RES_RDATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_OP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_OP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_OP_SUB;
            pc_write  = zero ^ funct3[0];
         end
         S_JAL: begin
            // PC takes OldPC+imm already computed in DECODE; ALU forms PC+4 for rd.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase

      if (rst) begin
         pc_write      = 1'b0;
         ir_write      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios with literal expectations, then
// randomized instruction streams checked every cycle against a sequence-table model.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic       alu_f7b5, illegal_instr;
   logic [3:0] state_dbg;

   int total = 0;
   int bad   = 0;
   int mstate = 0;

   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

   int ld_st[7]  = '{0, 1, 2, 3, 3, 3, 4};
   int ld_rdy[7] = '{1, 1, 1, 0, 0, 1, 1};
   logic [6:0] op_pool[6] = '{LD, ST, RT, IT, BR, JL};

   multicycle_control_fsm dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .alu_f7b5(alu_f7b5), .imm_src(imm_src),
      .illegal_instr(illegal_instr), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Model: each instruction class is a fixed list of states; memory states repeat while not ready.
   function automatic int model_next(int s, logic [6:0] o, logic rdy);
      int seq[$];
      if ((s == 0 || s == 3 || s == 5) && !rdy) return s;
      case (o)
         LD:      seq = '{0, 1, 2, 3, 4};
         ST:      seq = '{0, 1, 2, 5};
         RT:      seq = '{0, 1, 6, 8};
         IT:      seq = '{0, 1, 7, 8};
         BR:      seq = '{0, 1, 9};
         JL:      seq = '{0, 1, 10, 8};
         default: seq = '{0, 1};
      endcase
      for (int i = 0; i + 1 < seq.size(); i++)
         if (seq[i] == s) return seq[i+1];
      return 0;
   endfunction

   // Expected {pc_write,adr_src,mem_write,ir_write,reg_write,result_src,a,b,alu_op,f7b5,imm_src,illegal,state}
   function automatic logic [22:0] model_out(int s, logic [6:0] o, logic [2:0] f3, logic f7,
                                             logic z, logic rdy, logic r);
      logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
      logic [1:0] res = 0, a = 0, b = 0, aop = 0, imm = 0;
      logic [3:0] st = s[3:0];
      case (s)
         0:  begin irw = rdy; pcw = rdy; b = 2; res = 2; end
         1:  begin a = 1; b = 1; ill = !(o inside {LD, ST, RT, IT, BR, JL}); end
         2:  begin a = 2; b = 1; end
         3:  adr = 1;
         4:  begin res = 1; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  begin a = 2; b = 0; aop = 2; end
         7:  begin a = 2; b = 1; aop = 2; end
         8:  rw = 1;
         9:  begin a = 2; aop = 1; pcw = z ^ f3[0]; end
         10: begin a = 1; b = 2; pcw = 1; end
         default: ;
      endcase
      if (r) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
      imm = (o == ST) ? 2'd1 : (o == BR) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
      return {pcw, adr, mw, irw, rw, res, a, b, aop, f7 & o[5], imm, ill, st};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) mstate <= 0;
      else     mstate <= model_next(mstate, op, mem_ready);
   end

   always @(negedge clk) begin
      logic [22:0] act, exp_v;
      act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
             alu_src_b, alu_op, alu_f7b5, imm_src, illegal_instr, state_dbg};
      exp_v = model_out(mstate, op, funct3, funct7b5, zero, mem_ready, rst);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL cycle_cmp t=%0t got=%06h expected=%06h (op=%b state_model=%0d)",
                  $time, act, exp_v, op, mstate);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic step(input logic rdy, input logic z, input int exp_st);
      mem_ready = rdy; zero = z; #1;
      chk("state_dbg", {28'd0, state_dbg}, exp_st);
      chk("model_state", mstate, exp_st);
   endtask

   initial begin
      rst = 1; op = LD; funct3 = 0; funct7b5 = 0; zero = 0; mem_ready = 1;
      #2;
      chk("rst_state", {28'd0, state_dbg}, 0);
      chk("rst_ir_write", {31'd0, ir_write}, 0);
      chk("rst_pc_write", {31'd0, pc_write}, 0);
      chk("rst_alu_src_b", {30'd0, alu_src_b}, 2);
      @(posedge clk); #1 rst = 0;

      // Load with two wait cycles in MEMREAD
      for (int i = 0; i < 7; i++) begin
         step(ld_rdy[i], 0, ld_st[i]);
         chk("ld_reg_write", {31'd0, reg_write}, (ld_st[i] == 4) ? 1 : 0);
         if (ld_st[i] == 4) chk("ld_result_src", {30'd0, result_src}, 1);
         if (i == 0) chk("fetch_ir_write", {31'd0, ir_write}, 1);
         tick();
      end

      // R-type sub
      op = RT; funct7b5 = 1;
      step(1, 0, 0); tick(); step(1, 0, 1); tick();
      step(1, 0, 6);
      chk("r_alu_op", {30'd0, alu_op}, 2);
      chk("r_alu_f7b5", {31'd0, alu_f7b5}, 1);
      tick(); step(1, 0, 8);
      chk("r_reg_write", {31'd0, reg_write}, 1);
      tick();

      // addi with negative immediate
      op = IT; funct7b5 = 1;
      step(1, 0, 0); tick(); step(1, 0, 1); tick();
      step(1, 0, 7);
      chk("addi_f7b5", {31'd0, alu_f7b5}, 0);
      chk("addi_imm_src", {30'd0, imm_src}, 0);
      tick(); step(1, 0, 8); tick();

      // beq taken, bne not taken, both with zero=1
      op = BR; funct7b5 = 0;
      for (int k = 0; k < 2; k++) begin
         funct3 = (k == 0) ? 3'b000 : 3'b001;
         step(1, 1, 0); tick(); step(1, 1, 1);
         chk("br_imm_src", {30'd0, imm_src}, 2);
         tick(); step(1, 1, 9);
         chk(k == 0 ? "beq_pc_write" : "bne_pc_write", {31'd0, pc_write}, (k == 0) ? 1 : 0);
         tick();
      end
      funct3 = 0;

      // Illegal opcode (lui is unsupported)
      op = 7'b0110111;
      step(1, 0, 0); tick(); step(1, 0, 1);
      chk("illegal_pulse", {31'd0, illegal_instr}, 1);
      tick(); step(1, 0, 0);
      chk("illegal_clear", {31'd0, illegal_instr}, 0);

      // jal
      op = JL;
      tick(); step(1, 0, 1); tick();
      step(1, 0, 10);
      chk("jal_pc_write", {31'd0, pc_write}, 1);
      tick(); step(1, 0, 8);
      chk("jal_reg_write", {31'd0, reg_write}, 1);
      tick();

      // Reset in the middle of a stalled store
      op = ST;
      step(1, 0, 0); tick(); step(1, 0, 1); tick(); step(1, 0, 2); tick();
      step(0, 0, 5);
      chk("st_mem_write", {31'd0, mem_write}, 1);
      tick(); step(0, 0, 5);
      #1 rst = 1; #1;
      chk("rst_mid_state", {28'd0, state_dbg}, 0);
      chk("rst_mid_mem_write", {31'd0, mem_write}, 0);
      mem_ready = 1;
      tick(); rst = 0;
      step(1, 0, 0); tick();
      step(1, 0, 1);

      // Randomized instruction stream
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (rst) rst = 0;
         else if ($urandom_range(0, 199) == 0) rst = 1;
         mem_ready = ($urandom_range(0, 3) != 0);
         zero      = 1'($urandom);
         funct3    = 3'($urandom);
         funct7b5  = 1'($urandom);
         if (mstate == 0) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = op_pool[$urandom_range(0, 5)];
         end
      end
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath mux select and write enable. Produces the 2-bit `alu_op` and a qualified `funct7b5` that feed the ALU decoder directly. Waits on a memory-ready handshake for instruction fetch, load and store.

## Interface
Parameters: none.

Ports (all widths in bits):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 7: instruction[6:0], taken from the instruction register.
- `funct3` in 3: instruction[14:12].
- `funct7b5` in 1: instruction[30].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: data memory write strobe.
- `ir_write` out 1: instruction register and OldPC enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result select. 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: ALU B select. 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode by funct3/funct7.
- `alu_f7b5` out 1: `funct7b5 & op[5]`. This is the ALU decoder's funct7b5 input, forced 0 for I-type so that addi never subtracts.
- `imm_src` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal_instr` out 1: one-cycle pulse in DECODE when `op` is unsupported.
- `state_dbg` out 4: current state encoding, for debug.

## Operation
States, in encoding order 0..10. Unlisted outputs are 0 (selects 00).
- FETCH (0): `ir_write`=1 and `pc_write`=1 only in a cycle where `mem_ready`=1. `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `mem_ready`=1: go to DECODE. Otherwise stay.
- DECODE (1): `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). Next state by `op`:
  - 0000011 (load) or 0100011 (store): MEMADR.
  - 0110011 (R-type): EXECUTER.
  - 0010011 (I-ALU): EXECUTEI.
  - 1100011 (branch): BRANCH.
  - 1101111 (jal): JAL.
  - Anything else: `illegal_instr`=1, go to FETCH.
- MEMADR (2): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next: MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD (3): `adr_src`=1, `result_src`=00. Wait for `mem_ready`, then MEMWB.
- MEMWB (4): `result_src`=01, `reg_write`=1. Next: FETCH.
- MEMWRITE (5): `adr_src`=1, `mem_write`=1 held until the cycle `mem_ready`=1 (inclusive). Then FETCH.
- EXECUTER (6): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next: ALUWB.
- EXECUTEI (7): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next: ALUWB.
- ALUWB (8): `result_src`=00, `reg_write`=1. Next: FETCH.
- BRANCH (9): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero ^ funct3[0]`: beq takes the branch on zero=1, bne on zero=0.
  - Other funct3 values are treated as beq/bne by bit 0.
  - Next: FETCH.
- JAL (10): `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Next: ALUWB, which writes PC+4 to rd.
- Encodings 11–15: all outputs 0, next FETCH.

`imm_src` is combinational from `op`, independent of state:
- 0100011: 01.
- 1100011: 10.
- 1101111: 11.
- All other opcodes: 00.

## Timing
- State register updates on the rising edge of `clk`. Every output is combinational from state, plus `mem_ready`, `zero`, `funct3` and `op` where noted above. There are no registered outputs.
- Reset:
  - `rst` asserted: state goes to FETCH immediately (asynchronous).
  - While `rst`=1, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal_instr` are forced to 0. Selects show FETCH values.
  - First fetch can complete in the first edge after `rst` deasserts.
  - Reset mid-instruction abandons it; no partial writeback occurs after the reset edge.
- Latency with `mem_ready` tied to 1:
  - Load: 5 cycles.
  - Store, R-type, I-ALU, jal: 4 cycles.
  - Branch: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while waiting.
- `mem_ready` is ignored in all other states.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum (4-bit),
  - opcode constants,
  - `alu_op` constants,
  - `result_src`, `alu_src_a`, `alu_src_b` and `imm_src` constants.
- The ALU decoder imports the `alu_op` constants from the same package.
- One sub-module: `imm_src_decoder`, the combinational `op` → `imm_src` mapping, shared with the immediate extender.

## Test plan
- **Reset:** assert `rst` mid-MEMWRITE → `state_dbg`=0 and `mem_write`=0 in the same cycle. Deassert with `mem_ready`=1 → DECODE after 1 edge.
- **Load with wait:** `op`=0000011, `mem_ready`=0 for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. `reg_write`=1 only in state 4, with `result_src`=01.
- **R-type sub:** `op`=0110011, `funct7b5`=1 → EXECUTER shows `alu_op`=10, `alu_f7b5`=1. Then ALUWB with `reg_write`=1.
- **addi:** `op`=0010011, `funct7b5`=1 (negative immediate) → `alu_f7b5`=0, `imm_src`=00.
- **Branches:**
  - beq (`funct3`=000), `zero`=1 → `pc_write`=1.
  - bne (`funct3`=001), `zero`=1 → `pc_write`=0.
  - Both return to FETCH next cycle.
- **Illegal and jal:**
  - `op`=0110111 → `illegal_instr`=1 for exactly one cycle, then FETCH.
  - jal → `pc_write`=1 in state 10, then ALUWB writes rd.
